// File: rtl/figure_pkg.sv
// Shared types and default geometry for the player figure (motion and draw stages).
package figure_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_state_t;

    localparam int SCREEN_W     = 1024;
    localparam int SPRITE_BASE  = 26;
    localparam int SPRITE_SCALE = 2;
    localparam int SPRITE_SIZE  = SPRITE_BASE * SPRITE_SCALE;

    localparam logic [11:0] DEF_START_X  = 12'd100;
    localparam logic [11:0] DEF_GROUND_Y = 12'd500;
    localparam logic [11:0] DEF_X_MIN    = 12'd0;
    localparam logic [11:0] DEF_X_MAX    = 12'(SCREEN_W - SPRITE_SIZE);
    localparam logic [7:0]  DEF_STEP_X   = 8'd2;
    localparam logic [7:0]  DEF_JUMP_V0  = 8'd12;
    localparam logic [7:0]  DEF_GRAVITY  = 8'd1;
    localparam logic [7:0]  DEF_MAX_FALL = 8'd12;

    // Fall speed after one frame of gravity, saturated at terminal velocity.
    function automatic logic [7:0] fall_speed(input logic [7:0] vel,
                                              input logic [7:0] grav,
                                              input logic [7:0] max_v);
        logic [8:0] sum;
        sum = {1'b0, vel} + {1'b0, grav};
        return (sum > {1'b0, max_v}) ? max_v : sum[7:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle registered pulse on each rising edge of vblnk.
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vblnk,
    output logic o_frame_tick
);

    logic r_vblnk_d;
    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vblnk_d <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vblnk_d <= i_vblnk;
            r_tick    <= i_vblnk & ~r_vblnk_d;
        end
    end

    assign o_frame_tick = r_tick;

endmodule

// File: rtl/figure_motion_ctrl.sv
// Per-frame figure motion: clamped horizontal walk plus ground/rise/fall jump with gravity.
module figure_motion_ctrl
    import figure_pkg::*;
#(
    parameter logic [11:0] START_X  = DEF_START_X,
    parameter logic [11:0] GROUND_Y = DEF_GROUND_Y,
    parameter logic [11:0] X_MIN    = DEF_X_MIN,
    parameter logic [11:0] X_MAX    = DEF_X_MAX,
    parameter logic [7:0]  STEP_X   = DEF_STEP_X,
    parameter logic [7:0]  JUMP_V0  = DEF_JUMP_V0,
    parameter logic [7:0]  GRAVITY  = DEF_GRAVITY,
    parameter logic [7:0]  MAX_FALL = DEF_MAX_FALL
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vblnk,
    input  logic        i_move_left,
    input  logic        i_move_right,
    input  logic        i_jump,
    input  logic        i_freeze,
    output logic [11:0] o_rect_posx,
    output logic [11:0] o_rect_posy,
    output logic        o_facing,
    output logic        o_airborne,
    output logic        o_frame_tick
);

    motion_state_t r_state;
    logic [11:0]   r_posx;
    logic [11:0]   r_posy;
    logic [7:0]    r_vel;
    logic          r_facing;
    logic          r_airborne;

    logic          w_tick;
    logic          w_update;
    logic [12:0]   w_x_add;
    logic [11:0]   w_x_left;
    logic [11:0]   w_x_right;
    logic [7:0]    w_vn;
    logic [12:0]   w_fall_y;
    logic          w_ceiling;

    frame_tick_gen u_tick (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_vblnk      (i_vblnk),
        .o_frame_tick (w_tick)
    );

    assign w_update = w_tick & ~i_freeze;

    // 13-bit arithmetic so a step near either edge cannot wrap before clamping.
    always_comb begin
        w_x_add   = {1'b0, r_posx} + {5'b0, STEP_X};
        w_x_left  = ({1'b0, r_posx} < ({1'b0, X_MIN} + {5'b0, STEP_X}))
                    ? X_MIN : (r_posx - {4'b0, STEP_X});
        w_x_right = (w_x_add > {1'b0, X_MAX}) ? X_MAX : w_x_add[11:0];
        w_vn      = fall_speed(r_vel, GRAVITY, MAX_FALL);
        w_fall_y  = {1'b0, r_posy} + {5'b0, w_vn};
        w_ceiling = r_posy < {4'b0, r_vel};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= GROUND;
            r_posx     <= START_X;
            r_posy     <= GROUND_Y;
            r_vel      <= 8'd0;
            r_facing   <= 1'b0;
            r_airborne <= 1'b0;
        end else if (w_update) begin
            if (i_move_left && !i_move_right) begin
                r_posx   <= w_x_left;
                r_facing <= 1'b1;
            end else if (i_move_right && !i_move_left) begin
                r_posx   <= w_x_right;
                r_facing <= 1'b0;
            end

            case (r_state)
                GROUND: begin
                    if (i_jump) begin
                        r_vel      <= JUMP_V0 - GRAVITY;
                        r_posy     <= r_posy - {4'b0, JUMP_V0};
                        r_state    <= RISE;
                        r_airborne <= 1'b1;
                    end else begin
                        r_posy <= GROUND_Y;
                    end
                end
                RISE: begin
                    if (w_ceiling) begin
                        r_posy  <= 12'd0;
                        r_vel   <= 8'd0;
                        r_state <= FALL;
                    end else begin
                        r_posy <= r_posy - {4'b0, r_vel};
                        // Apex reached once gravity has eaten all upward speed.
                        if (r_vel <= GRAVITY) begin
                            r_vel   <= 8'd0;
                            r_state <= FALL;
                        end else begin
                            r_vel <= r_vel - GRAVITY;
                        end
                    end
                end
                FALL: begin
                    if (w_fall_y >= {1'b0, GROUND_Y}) begin
                        r_posy     <= GROUND_Y;
                        r_vel      <= 8'd0;
                        r_state    <= GROUND;
                        r_airborne <= 1'b0;
                    end else begin
                        r_posy <= w_fall_y[11:0];
                        r_vel  <= w_vn;
                    end
                end
                default: begin
                    r_state    <= GROUND;
                    r_posy     <= GROUND_Y;
                    r_vel      <= 8'd0;
                    r_airborne <= 1'b0;
                end
            endcase
        end
    end

    assign o_rect_posx  = r_posx;
    assign o_rect_posy  = r_posy;
    assign o_facing     = r_facing;
    assign o_airborne   = r_airborne;
    assign o_frame_tick = w_tick;

endmodule

// File: tb/tb_figure_motion_ctrl.sv
// Scoreboard bench: each issued frame pushes its expected figure state, a monitor checks it
// one cycle after the DUT's frame_tick pulse.
module tb_figure_motion_ctrl;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        f;
        logic        a;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic        moveLeft;
    logic        moveRight;
    logic        jump;
    logic        freeze;
    logic [11:0] posX;
    logic [11:0] posY;
    logic        facing;
    logic        airborne;
    logic        frameTick;

    exp_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   vblnkRises = 0;
    int   tickPulses = 0;
    int   yTab[24]   = '{488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422,
                         423, 425, 428, 432, 437, 443, 450, 458, 467, 477, 488, 500};

    figure_motion_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_vblnk      (vblnk),
        .i_move_left  (moveLeft),
        .i_move_right (moveRight),
        .i_jump       (jump),
        .i_freeze     (freeze),
        .o_rect_posx  (posX),
        .o_rect_posy  (posY),
        .o_facing     (facing),
        .o_airborne   (airborne),
        .o_frame_tick (frameTick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        checks++;
        if (posX !== e.x || posY !== e.y || facing !== e.f || airborne !== e.a) begin
            errors++;
            $display("[TB] FAIL %s: got x=%0d y=%0d facing=%0b airborne=%0b, expected x=%0d y=%0d facing=%0b airborne=%0b",
                     e.tag, posX, posY, facing, airborne, e.x, e.y, e.f, e.a);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic j, input logic fz,
                                 input int ex, input int ey, input logic ef, input logic ea,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        moveLeft  = l;
        moveRight = r;
        jump      = j;
        freeze    = fz;
        e.x = 12'(ex);
        e.y = 12'(ey);
        e.f = ef;
        e.a = ea;
        e.tag = tag;
        expQ.push_back(e);
        vblnk = 1'b1;
        vblnkRises++;
        repeat (2) @(negedge clk);
        vblnk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frameTick === 1'b1) begin
                tickPulses++;
                @(negedge clk);
                if (frameTick === 1'b1) tickPulses++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tick: got a frame_tick, required none pending");
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL timeout: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        exp_t e;
        int   ex;
        rst       = 1'b1;
        vblnk     = 1'b0;
        moveLeft  = 1'b0;
        moveRight = 1'b0;
        jump      = 1'b0;
        freeze    = 1'b0;
        repeat (3) @(negedge clk);
        e = '{x: 12'd100, y: 12'd500, f: 1'b0, a: 1'b0, tag: "reset"};
        checkOutput(e);
        checks++;
        if (frameTick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tick: got %0b, required 0", frameTick);
        end
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 0, 100, 500, 0, 0, "idle");

        for (int i = 0; i < 24; i++)
            applyStimulus(0, 0, i == 0, 0, 100, yTab[i], 0, i != 23, "jump1");

        // Jump with right held, a freeze during RISE and jump re-held through FALL.
        ex = 100;
        for (int i = 0; i < 25; i++) begin
            ex += 2;
            applyStimulus(0, 1, (i == 0) || (i >= 12), 0, ex,
                          (i < 24) ? yTab[i] : 488, 0, (i < 23) || (i == 24), "jump2");
            if (i == 3)
                for (int k = 0; k < 5; k++)
                    applyStimulus(0, 1, 1, 1, ex, yTab[3], 0, 1, "freeze");
        end

        for (int k = 1; k < 5; k++)
            applyStimulus(0, 0, 0, 0, 150, yTab[k], 0, 1, "jump3");

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = '{x: 12'd100, y: 12'd500, f: 1'b0, a: 1'b0, tag: "midjump_reset"};
        checkOutput(e);

        // Walk right to the edge while jumping once after the reset.
        for (int i = 0; i < 435; i++)
            applyStimulus(0, 1, i == 0, 0, 100 + 2 * (i + 1),
                          (i < 24) ? yTab[i] : 500, 0, i < 23, "walk_right");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 0, 972, 500, 0, 0, "clamp_right");
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 0, 0, 972, 500, 0, 0, "both_right");
        for (int i = 0; i < 486; i++)
            applyStimulus(1, 0, 0, 0, 972 - 2 * (i + 1), 500, 1, 0, "walk_left");
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 0, 0, 0, 0, 500, 1, 0, "clamp_left");
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 0, 0, 0, 500, 1, 0, "both_left");

        repeat (10) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending: got %0d unchecked frames, required 0", expQ.size());
        end
        checks++;
        if (tickPulses != vblnkRises) begin
            errors++;
            $display("[TB] FAIL tick_count: got %0d tick cycles, required %0d", tickPulses, vblnkRises);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
